// File: rtl/stack_guard_if.sv
// Bus between stack_guard and the register-backup stack.
// The master drives the stack strobes and data; the slave returns the stack output q.
interface stack_guard_if #(
  parameter int DATA_W = 32
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] d;
  logic              hold;
  logic              clear;
  logic [DATA_W-1:0] q;

  modport master (output push, pop, d, hold, clear, input q);
  modport slave  (input push, pop, d, hold, clear, output q);
endinterface

// File: rtl/stack_guard.sv
// Push/pop gatekeeper for the register-backup stack.
// It tracks depth and peak, returns pop data, and flags overflow, underflow and collision.
module stack_guard #(
  parameter int DEPTH  = 128,
  parameter int PTR_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic [DATA_W-1:0] req_d,
  input  logic              hold,
  input  logic              clear,
  stack_guard_if.master     stk,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [PTR_W:0]    depth,
  output logic [PTR_W:0]    peak,
  output logic              full,
  output logic              empty,
  output logic [2:0]        err_code,
  input  logic              err_ack,
  output logic              irq
);

  logic              go;
  logic              collision;
  logic              push_only;
  logic              pop_only;
  logic              pop_acc;
  logic [2:0]        events;
  logic [PTR_W:0]    depth_nxt;
  logic [DATA_W-1:0] last_q;

  assign full  = (depth == (PTR_W+1)'(DEPTH));
  assign empty = (depth == '0);

  assign go        = !hold && !clear;
  assign collision = req_push && req_pop;
  assign push_only = req_push && !req_pop;
  assign pop_only  = req_pop && !req_push;

  // Strobes depend only on requests and registered depth, never on stk.q.
  assign stk.push  = push_only && !full;
  assign stk.pop   = pop_only && !empty;
  assign stk.d     = req_d;
  assign stk.hold  = hold;
  assign stk.clear = clear;

  assign pop_acc = stk.pop && go;
  assign events  = {collision, push_only && full, pop_only && empty};

  always_comb begin
    depth_nxt = depth;
    if (stk.push)
      depth_nxt = depth + 1'b1;
    else if (pop_acc)
      depth_nxt = depth - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      peak      <= '0;
      pop_valid <= 1'b0;
      last_q    <= '0;
      err_code  <= '0;
      irq       <= 1'b0;
    end else begin
      depth     <= depth_nxt;
      peak      <= (depth_nxt > peak) ? depth_nxt : peak;
      pop_valid <= pop_acc;
      if (pop_valid)
        last_q <= stk.q;
      err_code  <= (err_ack ? 3'b000 : err_code) | events;
      irq       <= |events;
    end
  end

  assign pop_data = pop_valid ? stk.q : last_q;

endmodule

// File: tb/tb_stack_guard.sv
// Directed bench for stack_guard with a queue-based reference model and a stack stand-in.
module tb_stack_guard;
  localparam int DEPTH  = 128;
  localparam int PTR_W  = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_push = 1'b0;
  logic              req_pop = 1'b0;
  logic [DATA_W-1:0] req_d = '0;
  logic              hold = 1'b0;
  logic              clear = 1'b0;
  logic              err_ack = 1'b0;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [PTR_W:0]    depth;
  logic [PTR_W:0]    peak;
  logic              full;
  logic              empty;
  logic [2:0]        err_code;
  logic              irq;

  stack_guard_if #(.DATA_W(DATA_W)) stk ();

  stack_guard #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req_push(req_push), .req_pop(req_pop), .req_d(req_d),
    .hold(hold), .clear(clear), .stk(stk), .pop_data(pop_data), .pop_valid(pop_valid),
    .depth(depth), .peak(peak), .full(full), .empty(empty), .err_code(err_code),
    .err_ack(err_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for the register-backup stack: pushes regardless of hold, pops only when go.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  int sp = 0;
  always @(posedge clk) begin
    if (reset) begin
      sp = 0;
      stk.q <= '0;
    end else if (stk.push && sp < DEPTH) begin
      mem[sp] = stk.d;
      sp++;
    end else if (stk.pop && !stk.hold && !stk.clear && sp > 0) begin
      sp--;
      stk.q <= mem[sp];
    end
  end

  // Reference model: the stack contents as a queue, plus the visible registers.
  logic [DATA_W-1:0] mq[$];
  int          m_peak = 0;
  logic [2:0]  m_err = '0;
  logic        m_irq = 1'b0;
  logic        m_pv = 1'b0;
  logic [31:0] m_pd = '0;
  always @(posedge clk) begin
    logic [2:0] ev;
    if (reset) begin
      mq.delete();
      m_peak = 0; m_err = '0; m_irq = 1'b0; m_pv = 1'b0; m_pd = '0;
    end else begin
      ev = '0;
      m_pv = 1'b0;
      if (req_push && req_pop) ev[2] = 1'b1;
      else if (req_push) begin
        if (mq.size() == DEPTH) ev[1] = 1'b1;
        else mq.push_back(req_d);
      end else if (req_pop) begin
        if (mq.size() == 0) ev[0] = 1'b1;
        else if (!hold && !clear) begin
          m_pd = mq.pop_back();
          m_pv = 1'b1;
        end
      end
      m_err = (err_ack ? 3'b000 : m_err) | ev;
      m_irq = |ev;
      if (mq.size() > m_peak) m_peak = mq.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("depth",     32'(depth),     32'(mq.size()));
      chk("peak",      32'(peak),      32'(m_peak));
      chk("full",      32'(full),      32'(mq.size() == DEPTH));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("err_code",  32'(err_code),  32'(m_err));
      chk("irq",       32'(irq),       32'(m_irq));
      chk("pop_valid", 32'(pop_valid), 32'(m_pv));
      chk("pop_data",  pop_data,       m_pd);
      chk("stk_push",  32'(stk.push),  32'(req_push && !req_pop && mq.size() < DEPTH));
      chk("stk_pop",   32'(stk.pop),   32'(req_pop && !req_push && mq.size() > 0));
      chk("stk_d",     stk.d,          req_d);
      chk("stk_hold",  32'(stk.hold),  32'(hold));
      chk("stk_clear", 32'(stk.clear), 32'(clear));
    end
  end

  task automatic drive(input logic rs, input logic rp, input logic rq, input logic [31:0] d,
                       input logic h, input logic c, input logic a);
    @(posedge clk);
    #1;
    reset = rs; req_push = rp; req_pop = rq; req_d = d; hold = h; clear = c; err_ack = a;
  endtask

  task automatic idle();            drive(0, 0, 0, 32'h0, 0, 0, 0); endtask
  task automatic push(input logic [31:0] d); drive(0, 1, 0, d, 0, 0, 0); endtask
  task automatic pop();             drive(0, 0, 1, 32'h0, 0, 0, 0); endtask
  task automatic ack();             drive(0, 0, 0, 32'h0, 0, 0, 1); endtask

  initial begin
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    idle();
    chk_en = 1'b1;
    #1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_err",   32'(err_code), 32'd0);
    chk("rst_pdata", pop_data, 32'd0);

    push(32'h11); push(32'h22); push(32'h33);
    pop();
    pop();  #1 chk("pop1", pop_data, 32'h33); chk("pop1_v", 32'(pop_valid), 32'd1);
    pop();  #1 chk("pop2", pop_data, 32'h22);
    idle(); #1 chk("pop3", pop_data, 32'h11); chk("pop3_v", 32'(pop_valid), 32'd1);
    chk("drain_depth", 32'(depth), 32'd0);
    chk("drain_peak",  32'(peak),  32'd3);
    idle(); #1 chk("pop_hold_data", pop_data, 32'h11); chk("pop_v_low", 32'(pop_valid), 32'd0);

    pop();  #1 chk("uflow_stk_pop", 32'(stk.pop), 32'd0);
    idle(); #1 chk("uflow_err", 32'(err_code), 32'b001); chk("uflow_irq", 32'(irq), 32'd1);
    ack();  #1 chk("uflow_irq_end", 32'(irq), 32'd0);
    idle(); #1 chk("ack_err", 32'(err_code), 32'b000);

    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
    idle(); #1 chk("full_128", 32'(full), 32'd1); chk("peak_128", 32'(peak), 32'd128);
    push(32'hdead); #1 chk("oflow_stk_push", 32'(stk.push), 32'd0);
    idle(); #1 chk("oflow_err", 32'(err_code), 32'b010); chk("oflow_irq", 32'(irq), 32'd1);
    pop();
    idle(); #1 chk("pop_128th", pop_data, 32'h17f); chk("depth_127", 32'(depth), 32'd127);

    for (int i = 0; i < 122; i++) pop();
    ack();
    drive(0, 1, 1, 32'h77, 0, 0, 0);
    #1 chk("col_push", 32'(stk.push), 32'd0); chk("col_pop", 32'(stk.pop), 32'd0);
    idle(); #1 chk("col_err", 32'(err_code), 32'b100); chk("col_irq", 32'(irq), 32'd1);
    chk("col_depth", 32'(depth), 32'd5);
    idle(); #1 chk("col_irq_end", 32'(irq), 32'd0);

    pop(); pop(); pop(); ack();
    drive(0, 0, 1, 32'h0, 1, 0, 0);
    idle(); #1 chk("hold_pv", 32'(pop_valid), 32'd0); chk("hold_depth", 32'(depth), 32'd2);
    pop();
    idle(); #1 chk("hold2_pv", 32'(pop_valid), 32'd1); chk("hold2_data", pop_data, 32'h101);
    chk("hold2_depth", 32'(depth), 32'd1);
    push(32'h55);
    drive(0, 0, 1, 32'h0, 0, 1, 0);
    idle(); #1 chk("clr_pv", 32'(pop_valid), 32'd0); chk("clr_depth", 32'(depth), 32'd2);
    pop();
    idle(); #1 chk("clr2_data", pop_data, 32'h55); chk("clr2_depth", 32'(depth), 32'd1);

    pop();
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    idle(); #1 chk("rst_mid_pv", 32'(pop_valid), 32'd0); chk("rst_mid_depth", 32'(depth), 32'd0);
    chk("rst_mid_pdata", pop_data, 32'd0); chk("rst_mid_peak", 32'(peak), 32'd0);
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_guard.md
# stack_guard

Front-end controller between the CPU pipeline's push/pop decode and the 128-entry register-backup stack. It gates every push/pop request so the stack pointer can never wrap. It tracks the stack depth and high-water mark, and returns pop results to the pipeline with a valid strobe. Illegal accesses (overflow, underflow, push+pop collision) are blocked, recorded in a sticky error register and signalled by a one-cycle interrupt pulse.

## Interface
- DEPTH, 128, number of stack entries; must be a power of two.
- PTR_W, 7, log2(DEPTH).
- DATA_W, 32, entry width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_push  in  1  pipeline push request.
- req_pop  in  1  pipeline pop request.
- req_d  in  DATA_W  push data.
- hold  in  1  pipeline stall; forwarded to the stack.
- clear  in  1  pipeline flush; forwarded to the stack.
- stk_push  out  1  push to stack (combinational).
- stk_pop  out  1  pop to stack (combinational).
- stk_d  out  DATA_W  equals req_d.
- stk_hold  out  1  equals hold.
- stk_clear  out  1  equals clear.
- stk_q  in  DATA_W  stack output; valid the cycle after an accepted pop.
- pop_data  out  DATA_W  popped value to the pipeline.
- pop_valid  out  1  one-cycle strobe marking a fresh pop_data.
- depth  out  PTR_W+1  entries in use, range 0..DEPTH.
- peak  out  PTR_W+1  highest depth since reset.
- full  out  1  depth==DEPTH.
- empty  out  1  depth==0.
- err_code  out  3  sticky flags: [0] underflow, [1] overflow, [2] collision.
- err_ack  in  1  clears err_code.
- irq  out  1  one-cycle pulse per error event.

## Operation
- Let go = !hold && !clear.
- **Collision:** req_push && req_pop in the same cycle.
  - Neither stk_push nor stk_pop is asserted.
  - Sets err_code[2] and pulses irq, regardless of go.
- **Push:** stk_push = req_push && !req_pop && !full.
  - If req_push && !req_pop && full: push blocked, err_code[1] set, irq pulsed.
- **Pop:** stk_pop = req_pop && !req_push && !empty.
  - If req_pop && !req_push && empty: pop blocked, err_code[0] set, irq pulsed.
  - A pop forwarded while hold or clear is high is not "accepted": the stack keeps its pointer, depth does not change, and no pop_valid is produced.
- **Accepted pop:** stk_pop && go. depth decrements by 1.
- **Accepted push:** stk_push. depth increments by 1; the stack pushes regardless of hold.
- **Peak:** peak <= max(peak, next depth) every cycle.
- **Pop return:**
  - pop_valid is registered and is high exactly in the cycle after an accepted pop.
  - While pop_valid is high, pop_data = stk_q, and stk_q is also captured into an internal last-value register.
  - Otherwise pop_data = the last-value register.
- **Error register:**
  - err_code <= (err_ack ? 0 : err_code) | new_events.
  - An event in the same cycle as err_ack remains set.
  - irq is registered and high in the cycle after any error event; back-to-back events give back-to-back pulses.
- **full / empty:** combinational decodes of depth.

## Timing
- Reset values: depth 0, peak 0, err_code 0, irq 0, pop_valid 0, pop_data 0 (last-value register 0). full=0 and empty=1 after reset.
- Reset mid-operation wins over every request. A pop accepted in the cycle before reset produces no pop_valid after reset.
- Pop latency: request in cycle N, pop_valid and data in cycle N+1.
- Push latency: depth updates at the end of cycle N; full is visible in N+1.
- Error latency: err_code and irq reflect the event in N+1.
- Wrap-around is impossible: depth saturates at DEPTH and 0 by construction; push at depth DEPTH-1 makes full.
- Back-to-back pops: one accepted pop per cycle; pop_valid stays high across consecutive cycles, each with new data.
- No combinational path from stk_q to any stk_* output.

## Test plan
- Reset, push 0x11,0x22,0x33, pop x3 -> pop_valid in cycles 1..3 after the first pop, data 0x33,0x22,0x11; depth 3→0; peak=3; empty=1.
- Pop on empty -> stk_pop=0; err_code=001 and irq=1 the next cycle; depth stays 0. err_ack -> err_code=000.
- 128 pushes then a 129th -> full=1 after the 128th; 129th blocked, err_code=010, irq pulse; pop returns the 128th value.
- req_push and req_pop together at depth 5 -> no stack strobe, depth 5, err_code=100, irq 1 cycle.
- Pop with hold=1 at depth 2, then hold=0 pop -> the first pop gives no pop_valid and depth stays 2; the second gives pop_valid and depth 1. The same check with clear=1.
- Pop in cycle N, reset in N+1 -> pop_valid=0, depth=0, pop_data=0 after reset.
